// File: rtl/dp_tap_pkg.sv
// Shared types and helpers for the debug-port TAP controller.
package dp_tap_pkg;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  // ir_sel picks the IR-side state, otherwise the DR-side state.
  function automatic logic is_shift(input tap_state_t s, input logic ir_sel);
    return ir_sel ? (s == SH_IR) : (s == SH_DR);
  endfunction

  function automatic logic is_capture(input tap_state_t s, input logic ir_sel);
    return ir_sel ? (s == CAP_IR) : (s == CAP_DR);
  endfunction

endpackage

// File: rtl/dp_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-low clear.
module dp_sync #(
  parameter int STAGES = 2
) (
  input  logic iclk,
  input  logic iresetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (!iresetn) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller oversampling tck/tms/tdi in the iclk domain;
// emits single-cycle capture/shift/update strobes and a falling-edge tdo.
module dp_tap_ctrl
  import dp_tap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iclk,
  input  logic       iresetn,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  input  logic       ir_sdo,
  input  logic       dr_sdo,
  output logic       tdi_s,
  output logic       shift_ir,
  output logic       clk_ir,
  output logic       update_ir,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       tlr,
  output logic [3:0] state
);

  logic       tck_sync, tms_sync, tdi_sync;
  logic       tck_d, tck_rise, tck_fall, tms_s;
  tap_state_t state_q, state_nxt;

  dp_sync #(.STAGES(SYNC_STAGES)) u_sync_tck (.iclk(iclk), .iresetn(iresetn), .d(tck), .q(tck_sync));
  dp_sync #(.STAGES(SYNC_STAGES)) u_sync_tms (.iclk(iclk), .iresetn(iresetn), .d(tms), .q(tms_sync));
  dp_sync #(.STAGES(SYNC_STAGES)) u_sync_tdi (.iclk(iclk), .iresetn(iresetn), .d(tdi), .q(tdi_sync));

  // Edge pulses are registered; tms/tdi get one matching flop so they line up with tck_rise.
  always_ff @(posedge iclk) begin
    if (!iresetn) begin
      tck_d    <= 1'b0;
      tck_rise <= 1'b0;
      tck_fall <= 1'b0;
      tms_s    <= 1'b0;
      tdi_s    <= 1'b0;
    end else begin
      tck_d    <= tck_sync;
      tck_rise <= tck_sync & ~tck_d;
      tck_fall <= ~tck_sync & tck_d;
      tms_s    <= tms_sync;
      tdi_s    <= tdi_sync;
    end
  end

  // NOTE: assigning a default before the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:     state_nxt = tms_s ? TLR    : RTI;
      RTI:     state_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Strobes decode the state being left, so shift_* is valid alongside its clk_* pulse.
  always_ff @(posedge iclk) begin
    if (!iresetn) begin
      state_q   <= TLR;
      tlr       <= 1'b1;
      clk_ir    <= 1'b0;
      shift_ir  <= 1'b0;
      update_ir <= 1'b0;
      clk_dr    <= 1'b0;
      shift_dr  <= 1'b0;
      update_dr <= 1'b0;
      tdo       <= 1'b0;
      tdo_en    <= 1'b0;
    end else begin
      clk_ir    <= 1'b0;
      clk_dr    <= 1'b0;
      update_ir <= 1'b0;
      update_dr <= 1'b0;
      if (tck_rise) begin
        state_q  <= state_nxt;
        tlr      <= (state_nxt == TLR);
        clk_ir   <= is_capture(state_q, 1'b1) | is_shift(state_q, 1'b1);
        shift_ir <= is_shift(state_q, 1'b1);
        clk_dr   <= is_capture(state_q, 1'b0) | is_shift(state_q, 1'b0);
        shift_dr <= is_shift(state_q, 1'b0);
      end
      if (tck_fall) begin
        update_ir <= (state_q == UPD_IR);
        update_dr <= (state_q == UPD_DR);
        tdo_en    <= is_shift(state_q, 1'b1) | is_shift(state_q, 1'b0);
        if (is_shift(state_q, 1'b1))      tdo <= ir_sdo;
        else if (is_shift(state_q, 1'b0)) tdo <= dr_sdo;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Self-checking bench for dp_tap_ctrl: pin-level history model plus directed and random scans.
module tb_dp_tap_ctrl;

  localparam int SYNC = 2;
  localparam int D    = SYNC + 1;

  logic       iclk = 1'b0;
  logic       iresetn = 1'b0;
  logic       tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic       tdo, tdo_en, ir_sdo, dr_sdo, tdi_s;
  logic       shift_ir, clk_ir, update_ir, shift_dr, clk_dr, update_dr, tlr;
  logic [3:0] state;

  dp_tap_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .iclk(iclk), .iresetn(iresetn), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .ir_sdo(ir_sdo), .dr_sdo(dr_sdo), .tdi_s(tdi_s),
    .shift_ir(shift_ir), .clk_ir(clk_ir), .update_ir(update_ir),
    .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
    .tlr(tlr), .state(state)
  );

  always #5 iclk = ~iclk;

  // Attached chains: 4-cell IR (captures 0001) and 8-cell DR (captures A5), LSB out first.
  logic [3:0] ir_chain = 4'h0;
  logic [7:0] dr_chain = 8'h00;
  always @(posedge iclk) begin
    if (clk_ir) ir_chain <= shift_ir ? {tdi_s, ir_chain[3:1]} : 4'b0001;
    if (clk_dr) dr_chain <= shift_dr ? {tdi_s, dr_chain[7:1]} : 8'hA5;
  end
  assign ir_sdo = ir_chain[0];
  assign dr_sdo = dr_chain[0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE 1149.1 transition table, indexed by state encoding.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  bit tck_h[$], tms_h[$], tdi_h[$];
  bit m_valid = 0;
  int m_state;
  bit m_tlr, m_clk_ir, m_shift_ir, m_upd_ir, m_clk_dr, m_shift_dr, m_upd_dr;
  bit m_tdo, m_tdo_en, m_tdi_s;

  // Model: pin samples taken at each iclk edge; an event is visible SYNC+2 edges after its first sample.
  initial forever begin
    @(posedge iclk);
    if (!iresetn) begin
      m_state = 0; m_tlr = 1;
      m_clk_ir = 0; m_shift_ir = 0; m_upd_ir = 0;
      m_clk_dr = 0; m_shift_dr = 0; m_upd_dr = 0;
      m_tdo = 0; m_tdo_en = 0; m_tdi_s = 0;
      tck_h = {}; tms_h = {}; tdi_h = {};
      for (int i = 0; i < D + 2; i++) begin
        tck_h.push_back(1'b0); tms_h.push_back(1'b0); tdi_h.push_back(1'b0);
      end
      m_valid = 1;
    end else begin
      tck_h.push_front(tck); void'(tck_h.pop_back());
      tms_h.push_front(tms); void'(tms_h.pop_back());
      tdi_h.push_front(tdi); void'(tdi_h.pop_back());
      m_clk_ir = 0; m_clk_dr = 0; m_upd_ir = 0; m_upd_dr = 0;
      if (tck_h[D] && !tck_h[D+1]) begin
        m_clk_ir   = (m_state == 10) || (m_state == 11);
        m_shift_ir = (m_state == 11);
        m_clk_dr   = (m_state == 3) || (m_state == 4);
        m_shift_dr = (m_state == 4);
        m_state    = tms_h[D] ? nxt1[m_state] : nxt0[m_state];
        m_tlr      = (m_state == 0);
      end
      if (!tck_h[D] && tck_h[D+1]) begin
        m_upd_ir = (m_state == 15);
        m_upd_dr = (m_state == 8);
        if (m_state == 11)     m_tdo = ir_sdo;
        else if (m_state == 4) m_tdo = dr_sdo;
        m_tdo_en = (m_state == 11) || (m_state == 4);
      end
      m_tdi_s = tdi_h[SYNC];
    end
  end

  int n_cap_ir = 0, n_sh_ir = 0, n_upd_ir = 0, n_cap_dr = 0, n_sh_dr = 0, n_upd_dr = 0;

  // Compare every cycle on the falling iclk edge, and tally strobes for the directed checks.
  initial forever begin
    @(negedge iclk);
    if (m_valid) begin
      check("state", state, 8'(m_state));
      check("tlr", tlr, m_tlr);
      check("clk_ir", clk_ir, m_clk_ir);
      check("shift_ir", shift_ir, m_shift_ir);
      check("update_ir", update_ir, m_upd_ir);
      check("clk_dr", clk_dr, m_clk_dr);
      check("shift_dr", shift_dr, m_shift_dr);
      check("update_dr", update_dr, m_upd_dr);
      check("tdo", tdo, m_tdo);
      check("tdo_en", tdo_en, m_tdo_en);
      check("tdi_s", tdi_s, m_tdi_s);
      if (clk_ir && !shift_ir) n_cap_ir++;
      if (clk_ir && shift_ir)  n_sh_ir++;
      if (update_ir)           n_upd_ir++;
      if (clk_dr && !shift_dr) n_cap_dr++;
      if (clk_dr && shift_dr)  n_sh_dr++;
      if (update_dr)           n_upd_dr++;
    end
  end

  task automatic tck_cycle(input bit t_ms, input bit t_di, input int lo = 4, input int hi = 4);
    tck = 1'b0; tms = t_ms; tdi = t_di;
    repeat (lo) @(negedge iclk);
    tck = 1'b1;
    repeat (hi) @(negedge iclk);
  endtask

  task automatic idle(input int n);
    tck = 1'b0;
    repeat (n) @(negedge iclk);
  endtask

  int snap_ir, snap_dr, snap_all;
  bit dr_tms [17] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
  bit ir_tdi [4]  = '{1, 0, 1, 1};
  bit ir_tms [4]  = '{0, 0, 0, 1};

  initial begin
    repeat (3) @(negedge iclk);
    iresetn = 1'b1;

    // Five tms=1 cycles hold TLR with no strobes.
    snap_all = n_cap_ir + n_sh_ir + n_upd_ir + n_cap_dr + n_sh_dr + n_upd_dr;
    repeat (5) tck_cycle(1'b1, 1'b0);
    idle(8);
    check("tlr5_state", state, 8'd0);
    check("tlr5_tlr", tlr, 1'b1);
    check("tlr5_pulses", 8'(n_cap_ir + n_sh_ir + n_upd_ir + n_cap_dr + n_sh_dr + n_upd_dr - snap_all), 8'd0);

    // TLR -> RTI -> SEL_DR -> SEL_IR -> CAP_IR -> SH_IR.
    snap_ir = n_cap_ir;
    tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    idle(8);
    check("ir_enter_state", state, 8'd11);
    check("ir_capture_cnt", 8'(n_cap_ir - snap_ir), 8'd1);
    check("ir_captured", ir_chain, 8'h01);

    // Shift 1,0,1,1 then EX1_IR -> UPD_IR -> RTI.
    snap_ir = n_sh_ir;
    snap_all = n_upd_ir;
    for (int i = 0; i < 4; i++) tck_cycle(ir_tms[i], ir_tdi[i]);
    tck_cycle(1, 0);
    tck_cycle(0, 0);
    idle(8);
    check("ir_shift_cnt", 8'(n_sh_ir - snap_ir), 8'd4);
    check("ir_update_cnt", 8'(n_upd_ir - snap_all), 8'd1);
    check("ir_chain", ir_chain, 8'h0D);
    check("ir_done_state", state, 8'd1);

    // DR scan with a 3-rise pause, then update.
    snap_dr = n_sh_dr;
    snap_all = n_cap_dr;
    snap_ir = n_upd_dr;
    for (int i = 0; i < 17; i++) tck_cycle(dr_tms[i], 1'($urandom_range(0, 1)));
    idle(8);
    check("dr_shift_cnt", 8'(n_sh_dr - snap_dr), 8'd7);
    check("dr_capture_cnt", 8'(n_cap_dr - snap_all), 8'd1);
    check("dr_update_cnt", 8'(n_upd_dr - snap_ir), 8'd1);
    check("dr_done_tdo_en", tdo_en, 1'b0);

    // Reset while in SH_IR.
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0); tck_cycle(0, 1);
    idle(8);
    check("pre_rst_state", state, 8'd11);
    check("pre_rst_tdo_en", tdo_en, 1'b1);
    snap_ir = n_upd_ir;
    iresetn = 1'b0;
    @(negedge iclk);
    check("rst_state", state, 8'd0);
    check("rst_shift_ir", shift_ir, 1'b0);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_tlr", tlr, 1'b1);
    iresetn = 1'b1;
    idle(8);
    check("rst_no_update", 8'(n_upd_ir - snap_ir), 8'd0);

    // Randomized scans with occasional resets; the per-cycle model checks everything.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        iresetn = 1'b0;
        @(negedge iclk);
        iresetn = 1'b1;
      end
      tck_cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                $urandom_range(2, 5), $urandom_range(2, 5));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_tap_ctrl.md
# dp_tap_ctrl

IEEE 1149.1 TAP controller for the debug port, running entirely in the internal clock domain. It oversamples the external `tck`/`tms`/`tdi` pins, detects `tck` edges, and steps the 16-state TAP state machine. It generates the single-cycle capture/shift/update strobes that drive the instruction-register cell chain and the data-register chain. It also registers `tdo` on falling `tck` edges.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `tck`/`tms`/`tdi` (≥2)
- `iclk` input 1 internal clock; must run ≥4× the `tck` frequency
- `iresetn` input 1 internal reset; one clock, reset synchronous, active-low
- `tck`, `tms`, `tdi` input 1 each: raw JTAG pins, asynchronous to `iclk`
- `tdo` output 1 serial output pin
- `tdo_en` output 1 high while `tdo` carries shift data
- `ir_sdo`, `dr_sdo` input 1 each: serial outputs of the IR chain and the selected DR
- `tdi_s` output 1 synchronized `tdi`, feeds the `sdi` of the first chain cell
- `shift_ir`, `clk_ir`, `update_ir` output 1 each: IR chain controls
- `shift_dr`, `clk_dr`, `update_dr` output 1 each: DR chain controls
- `tlr` output 1 high while in Test-Logic-Reset
- `state` output 4 current TAP state, for debug visibility

## Operation
- `tck`, `tms` and `tdi` each pass through a `SYNC_STAGES` flop chain. A further flop on synchronized `tck` produces `tck_rise` and `tck_fall`, each a one-`iclk` pulse. `tms` and `tdi` are delayed by the same number of stages as `tck`, so they are sampled aligned with `tck_rise`.
- States, in encoding order 0..15:
  - TLR, RTI
  - SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR
  - SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
- Transitions follow IEEE 1149.1 and occur only in cycles where `tck_rise`=1.
  - TLR: `tms`=0 goes to RTI; otherwise stays in TLR.
  - SEL_IR: `tms`=1 goes to TLR.
  - Five consecutive rises with `tms`=1 reach TLR from any state.
- In the `tck_rise` cycle, all of the following are registered together:
  - `clk_ir` ← state ∈ {CAP_IR, SH_IR}
  - `shift_ir` ← (state == SH_IR)
  - `clk_dr` and `shift_dr` follow the same rule for the DR states
  - Consequence: `shift_*` is valid in the same cycle as its `clk_*` pulse, and holds until the next rise. Capture (`shift`=0) and the final shift before exit (`shift`=1) are therefore both correct.
- In the `tck_fall` cycle:
  - `update_ir` ← (state == UPD_IR); `update_dr` ← (state == UPD_DR)
  - `tdo` ← `ir_sdo` when state == SH_IR, `dr_sdo` when state == SH_DR, otherwise `tdo` holds
  - `tdo_en` ← state ∈ {SH_IR, SH_DR}
- `clk_*` and `update_*` are single-cycle pulses. `shift_*`, `tdo`, `tdo_en` and `tlr` are levels.
- `tlr` ← (next state == TLR), registered with the state.

## Timing
- Reset (`iresetn`=0 at a rising `iclk` edge):
  - state=TLR, `tlr`=1
  - all strobes and `tdo_en` = 0, `tdo`=0
  - synchronizer and edge flops = 0
- The first `tck` high seen after reset does produce a rise.
- Latency from a pin transition to its registered strobe: `SYNC_STAGES`+2 `iclk` cycles.
- Reset mid-shift returns to TLR immediately. A strobe that would have fired in that cycle is suppressed.
- A `tck` high or low phase shorter than 2 `iclk` periods is unsupported; the behaviour is undefined.
- `tck_rise` and `tck_fall` can never be asserted in the same cycle.

## Structure
- Package `dp_tap_pkg`:
  - `tap_state_t` enum, 4 bits, with the encoding above
  - `is_shift`/`is_capture` helper functions
- Sub-module `dp_sync`: parameterized-depth single-bit synchronizer, instantiated three times.
- Next-state logic is a single combinational case on (`state`, `tms_s`). Outputs are registered as described above.

## Test plan
- Reset, then 5 `tck` cycles with `tms`=1 → `state`=TLR and `tlr`=1 throughout; no `clk_*` or `update_*` pulse.
- `tms` sequence 0,1,1,0,0 → CAP_IR then SH_IR. Check `clk_ir` pulses with `shift_ir`=0, then `clk_ir` pulses with `shift_ir`=1.
- Shift a 4-bit IR with `tdi`=1,0,1,1, `tms`=1 on the last bit, then `tms`=1 → exactly 4 shift pulses with `shift_ir`=1, and a `update_ir` pulse on the UPD_IR falling edge. An attached 4-cell IR chain holds 4'b1101.
- DR scan in SH_DR with `dr_sdo` toggling → `tdo` follows `dr_sdo` one `tck` fall later; `tdo_en`=1 only in SH_DR.
- Pause/exit path EX1_DR→PAU_DR (3 cycles)→EX2_DR→SH_DR → no `clk_dr` pulses during pause; shifting resumes.
- `iresetn` asserted while in SH_IR → next cycle `state`=TLR, `shift_ir`=0, `tdo_en`=0, and no `update_ir` pulse.
